// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the 32-bit core. Owns the PC and steps each
//   instruction through FETCH / DECODE / EXEC / MEM / WB. Every output comes
//   from a register or is Moore-decoded from the state plus the latched
//   opcode. There is no combinational path from instr to any output.
//
//   Optional feature: define SEQ_PERF_CNT_EN to add the cycle_cnt and
//   instr_cnt performance counters.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   leave IDLE/HALT and fetch at the current PC
//   instr[31:0]    in   instruction-memory data
//   alu_zero       in   ALU result is zero (beq decision)
//   dmem_ack       in   data-memory access complete
//   pc             out  current instruction word address
//   imem_read_en   out  instruction-memory read strobe
//   ir_load        out  datapath latches instr this cycle
//   reg_write_en   out  register-file write enable
//   reg_dest       out  1 = Rd, 0 = Rt destination
//   alu_src        out  1 = sign-extended immediate, 0 = Rt
//   mem_to_reg     out  writeback from data memory
//   dmem_read      out  load request, held until ack
//   dmem_write     out  store request, held until ack
//   alu_op[1:0]    out  00 add, 01 sub, 10 use func
//   busy           out  FSM not in IDLE/HALT
//   halted         out  HALT state
//   illegal        out  sticky unknown-opcode flag
//   cycle_cnt      out  (SEQ_PERF_CNT_EN) cycles spent busy
//   instr_cnt      out  (SEQ_PERF_CNT_EN) completed instructions
module multicycle_sequencer #(
   parameter int              PC_W     = 28,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [31:0]     instr,
   input  logic            alu_zero,
   input  logic            dmem_ack,
   output logic [PC_W-1:0] pc,
   output logic            imem_read_en,
   output logic            ir_load,
   output logic            reg_write_en,
   output logic            reg_dest,
   output logic            alu_src,
   output logic            mem_to_reg,
   output logic            dmem_read,
   output logic            dmem_write,
   output logic [1:0]      alu_op,
   output logic            busy,
   output logic            halted,
   output logic            illegal
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]     cycle_cnt,
   output logic [31:0]     instr_cnt
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // Jump target is truncated when the PC is narrower than 26 bits.
   localparam int JW = (PC_W < 26) ? PC_W : 26;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t          state_r, state_next;
   logic [PC_W-1:0] pc_r, pc_next;
   logic [5:0]      opcode_r;
   logic [25:0]     imm_r;
   logic            illegal_r, illegal_set;
   logic [PC_W-1:0] pc_inc_s, pc_br_s, pc_jump_s;

   // PC candidates; all arithmetic wraps modulo 2^PC_W.
   assign pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
   assign pc_br_s   = pc_inc_s + {{(PC_W-16){imm_r[15]}}, imm_r[15:0]};
   assign pc_jump_s = PC_W'(imm_r[JW-1:0]);

   assign pc      = pc_r;
   assign illegal = illegal_r;

   // State, PC, instruction latch and sticky illegal flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         pc_r      <= RESET_PC;
         opcode_r  <= 6'd0;
         imm_r     <= 26'd0;
         illegal_r <= 1'b0;
      end else begin
         state_r <= state_next;
         pc_r    <= pc_next;
         if (state_r == S_FETCH) begin
            opcode_r <= instr[31:26];
            imm_r    <= instr[25:0];
         end
         if (illegal_set) begin
            illegal_r <= 1'b1;
         end
      end
   end

   // Next-state, next-PC and Moore output decode.
   always_comb begin
      state_next   = state_r;
      pc_next      = pc_r;
      illegal_set  = 1'b0;
      imem_read_en = 1'b0;
      ir_load      = 1'b0;
      reg_write_en = 1'b0;
      reg_dest     = 1'b0;
      alu_src      = 1'b0;
      mem_to_reg   = 1'b0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      alu_op       = 2'b00;
      busy         = 1'b1;
      halted       = 1'b0;
      case (state_r)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_next = S_FETCH;
            else       state_next = S_IDLE;
         end
         S_FETCH: begin
            imem_read_en = 1'b1;
            ir_load      = 1'b1;
            state_next   = S_DECODE;
         end
         S_DECODE: begin
            case (opcode_r)
               OP_HALT: begin
                  // Resume from HALT continues at the following word.
                  pc_next    = pc_inc_s;
                  state_next = S_HALT;
               end
               OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: begin
                  state_next = S_EXEC;
               end
               default: begin
                  // Unknown opcode retires as a NOP.
                  illegal_set = 1'b1;
                  pc_next     = pc_inc_s;
                  state_next  = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            case (opcode_r)
               OP_RTYPE: begin
                  alu_op     = 2'b10;
                  state_next = S_WB;
               end
               OP_ADDI: begin
                  alu_src    = 1'b1;
                  state_next = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src    = 1'b1;
                  state_next = S_MEM;
               end
               OP_BEQ: begin
                  alu_op = 2'b01;
                  if (alu_zero) pc_next = pc_br_s;
                  else          pc_next = pc_inc_s;
                  state_next = S_FETCH;
               end
               OP_J: begin
                  pc_next    = pc_jump_s;
                  state_next = S_FETCH;
               end
               default: begin
                  pc_next    = pc_inc_s;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            alu_src = 1'b1;
            if (opcode_r == OP_LW) dmem_read  = 1'b1;
            else                   dmem_write = 1'b1;
            if (dmem_ack) begin
               if (opcode_r == OP_LW) begin
                  state_next = S_WB;
               end else begin
                  pc_next    = pc_inc_s;
                  state_next = S_FETCH;
               end
            end else begin
               state_next = S_MEM;
            end
         end
         S_WB: begin
            reg_write_en = 1'b1;
            reg_dest     = (opcode_r == OP_RTYPE);
            mem_to_reg   = (opcode_r == OP_LW);
            pc_next      = pc_inc_s;
            state_next   = S_FETCH;
         end
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
            if (start) state_next = S_FETCH;
            else       state_next = S_HALT;
         end
         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt_r, instr_cnt_r;
   logic        instr_done_s;

   // An instruction retires when control returns to FETCH from inside the
   // pipeline sequence, or when a halt is taken.
   assign instr_done_s = ((state_next == S_FETCH) && (state_r != S_IDLE) && (state_r != S_HALT))
                       || ((state_next == S_HALT) && (state_r == S_DECODE));

   // Free-running performance counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_r <= 32'd0;
         instr_cnt_r <= 32'd0;
      end else begin
         if (busy)         cycle_cnt_r <= cycle_cnt_r + 32'd1;
         if (instr_done_s) instr_cnt_r <= instr_cnt_r + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_r;
   assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (default build,
// PC_W = 28, RESET_PC = 0).
module tb_multicycle_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] instr;
   logic        alu_zero;
   logic        dmem_ack;
   logic [27:0] pc;
   logic        imem_read_en, ir_load, reg_write_en, reg_dest, alu_src;
   logic        mem_to_reg, dmem_read, dmem_write, busy, halted, illegal;
   logic [1:0]  alu_op;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] I_ADD    = 32'h00221820;
   localparam logic [31:0] I_LW     = 32'h8C220004;
   localparam logic [31:0] I_SW     = 32'hAC220004;
   localparam logic [31:0] I_BEQ_M2 = 32'h1000FFFE;
   localparam logic [31:0] I_J5     = 32'h08000005;
   localparam logic [31:0] I_JMAX   = 32'h0BFFFFFF;
   localparam logic [31:0] I_HALT   = 32'hFC000000;
   localparam logic [31:0] I_ILL    = 32'hF8000000;

   multicycle_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .instr        (instr),
      .alu_zero     (alu_zero),
      .dmem_ack     (dmem_ack),
      .pc           (pc),
      .imem_read_en (imem_read_en),
      .ir_load      (ir_load),
      .reg_write_en (reg_write_en),
      .reg_dest     (reg_dest),
      .alu_src      (alu_src),
      .mem_to_reg   (mem_to_reg),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .alu_op       (alu_op),
      .busy         (busy),
      .halted       (halted),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      instr    = 32'd0;
      alu_zero = 1'b0;
      dmem_ack = 1'b0;
      #2;
      check("rst_pc",      32'(pc), 32'h0);
      check("rst_busy",    32'(busy), 32'h0);
      check("rst_halted",  32'(halted), 32'h0);
      check("rst_illegal", 32'(illegal), 32'h0);
      check("rst_strobes", {26'd0, imem_read_en, ir_load, reg_write_en, dmem_read, dmem_write, alu_src}, 32'h0);
      step();
      rst = 1'b1;
      step();
      check("idle_busy", 32'(busy), 32'h0);

      // ---- add: F, D, E, W; dmem_ack held high must be ignored ----
      instr    = I_ADD;
      dmem_ack = 1'b1;
      start    = 1'b1;
      step();                                   // FETCH
      start = 1'b0;
      check("add_f_imem",  32'(imem_read_en), 32'h1);
      check("add_f_irld",  32'(ir_load), 32'h1);
      check("add_f_busy",  32'(busy), 32'h1);
      check("add_f_rwe",   32'(reg_write_en), 32'h0);
      step();                                   // DECODE
      check("add_d_rwe",   32'(reg_write_en), 32'h0);
      check("add_d_imem",  32'(imem_read_en), 32'h0);
      step();                                   // EXEC
      check("add_e_aluop", 32'(alu_op), 32'h2);
      check("add_e_src",   32'(alu_src), 32'h0);
      check("add_e_rwe",   32'(reg_write_en), 32'h0);
      step();                                   // WB
      check("add_w_rwe",   32'(reg_write_en), 32'h1);
      check("add_w_dest",  32'(reg_dest), 32'h1);
      check("add_w_m2r",   32'(mem_to_reg), 32'h0);
      check("add_w_pc",    32'(pc), 32'h0);
      step();                                   // FETCH
      check("add_end_rwe", 32'(reg_write_en), 32'h0);
      check("add_end_pc",  32'(pc), 32'h1);
      check("add_end_imem",32'(imem_read_en), 32'h1);
      dmem_ack = 1'b0;

      // ---- lw with ack delayed two cycles ----
      do_reset();
      instr = I_LW;
      start = 1'b1;
      step();                                   // c1 FETCH
      start = 1'b0;
      step();                                   // c2 DECODE
      step();                                   // c3 EXEC
      check("lw_e_src",    32'(alu_src), 32'h1);
      check("lw_e_aluop",  32'(alu_op), 32'h0);
      step();                                   // c4 MEM
      check("lw_m1_rd",    32'(dmem_read), 32'h1);
      check("lw_m1_wr",    32'(dmem_write), 32'h0);
      check("lw_m1_src",   32'(alu_src), 32'h1);
      step();                                   // c5 MEM
      check("lw_m2_rd",    32'(dmem_read), 32'h1);
      step();                                   // c6 MEM
      check("lw_m3_rd",    32'(dmem_read), 32'h1);
      dmem_ack = 1'b1;
      step();                                   // c7 WB
      dmem_ack = 1'b0;
      check("lw_w_rd",     32'(dmem_read), 32'h0);
      check("lw_w_rwe",    32'(reg_write_en), 32'h1);
      check("lw_w_m2r",    32'(mem_to_reg), 32'h1);
      check("lw_w_dest",   32'(reg_dest), 32'h0);
      step();                                   // FETCH
      check("lw_end_pc",   32'(pc), 32'h1);
      check("lw_end_rwe",  32'(reg_write_en), 32'h0);

      // ---- j 5, then beq -2 taken / not taken ----
      do_reset();
      instr = I_J5;
      start = 1'b1;
      step();                                   // FETCH
      start = 1'b0;
      step();                                   // DECODE
      step();                                   // EXEC
      check("j_e_aluop",   32'(alu_op), 32'h0);
      step();                                   // FETCH
      check("j5_pc",       32'(pc), 32'h5);
      instr    = I_BEQ_M2;
      alu_zero = 1'b1;
      step();                                   // DECODE
      step();                                   // EXEC
      check("beq_e_aluop", 32'(alu_op), 32'h1);
      check("beq_e_src",   32'(alu_src), 32'h0);
      check("beq_e_rwe",   32'(reg_write_en), 32'h0);
      step();                                   // FETCH
      check("beq_tk_pc",   32'(pc), 32'h4);
      check("beq_tk_rwe",  32'(reg_write_en), 32'h0);
      instr = I_J5;
      step();
      step();
      step();                                   // FETCH at 5
      instr    = I_BEQ_M2;
      alu_zero = 1'b0;
      step();
      step();                                   // EXEC
      check("beq_nt_rwe",  32'(reg_write_en), 32'h0);
      step();                                   // FETCH
      check("beq_nt_pc",   32'(pc), 32'h6);

      // ---- j to maximum 26-bit target ----
      instr = I_JMAX;
      step();
      step();
      step();
      check("jmax_pc",     32'(pc), 32'h03FFFFFF);

      // ---- branch wrap to all-ones, then add wraps to 0 ----
      do_reset();
      instr    = I_BEQ_M2;
      alu_zero = 1'b1;
      start    = 1'b1;
      step();                                   // FETCH pc=0
      start = 1'b0;
      step();
      step();
      step();                                   // FETCH
      check("brwrap_pc",   32'(pc), 32'h0FFFFFFF);
      alu_zero = 1'b0;
      instr    = I_ADD;
      step();
      step();
      step();
      step();                                   // FETCH
      check("incwrap_pc",  32'(pc), 32'h0);

      // ---- halt, restart, then illegal opcode ----
      do_reset();
      instr = I_HALT;
      start = 1'b1;
      step();                                   // FETCH
      start = 1'b0;
      step();                                   // DECODE
      step();                                   // HALT
      check("halt_halted", 32'(halted), 32'h1);
      check("halt_busy",   32'(busy), 32'h0);
      check("halt_pc",     32'(pc), 32'h1);
      step();
      check("halt_stay",   32'(halted), 32'h1);
      start = 1'b1;
      step();                                   // FETCH
      start = 1'b0;
      check("resume_halt", 32'(halted), 32'h0);
      check("resume_busy", 32'(busy), 32'h1);
      check("resume_pc",   32'(pc), 32'h1);
      instr = I_ILL;
      step();                                   // DECODE
      check("ill_d_flag",  32'(illegal), 32'h0);
      step();                                   // FETCH
      check("ill_flag",    32'(illegal), 32'h1);
      check("ill_pc",      32'(pc), 32'h2);
      check("ill_fetch",   32'(imem_read_en), 32'h1);
      instr = I_ADD;
      step();
      step();
      step();
      step();                                   // FETCH
      check("ill_sticky",  32'(illegal), 32'h1);
      check("ill_next_pc", 32'(pc), 32'h3);

      // ---- sw, reset while waiting for ack ----
      do_reset();
      check("rst_clr_ill", 32'(illegal), 32'h0);
      instr = I_SW;
      start = 1'b1;
      step();                                   // FETCH
      start = 1'b0;
      step();                                   // DECODE
      step();                                   // EXEC
      check("sw_e_src",    32'(alu_src), 32'h1);
      step();                                   // MEM
      check("sw_m_wr",     32'(dmem_write), 32'h1);
      check("sw_m_rd",     32'(dmem_read), 32'h0);
      step();                                   // MEM, no ack
      check("sw_m2_wr",    32'(dmem_write), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check("swrst_wr",    32'(dmem_write), 32'h0);
      check("swrst_busy",  32'(busy), 32'h0);
      check("swrst_pc",    32'(pc), 32'h0);
      check("swrst_rwe",   32'(reg_write_en), 32'h0);
      step();
      rst = 1'b1;
      step();
      check("swrst_idle",  32'(busy), 32'h0);

      // ---- sw with zero-wait ack: 4 cycles, pc+1 ----
      instr    = I_SW;
      dmem_ack = 1'b1;
      start    = 1'b1;
      step();                                   // FETCH
      start = 1'b0;
      step();
      step();
      step();                                   // MEM
      check("sw0_wr",      32'(dmem_write), 32'h1);
      step();                                   // FETCH
      dmem_ack = 1'b0;
      check("sw0_pc",      32'(pc), 32'h1);
      check("sw0_wr_off",  32'(dmem_write), 32'h0);
      check("sw0_rwe",     32'(reg_write_en), 32'h0);
      check("sw0_fetch",   32'(imem_read_en), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit core. It owns the PC and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives instruction-memory read enable, register-file write enable, ALU source/op and data-memory request strobes.
- Replaces the per-cycle, single-cycle use of the combinational control unit. Sits between instruction memory, register block, ALU and data memory.

Parameters:
- PC_W, 28, PC / instruction-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  leave IDLE/HALT and begin fetching at current PC
- instr  in  32  instruction-memory data
- alu_zero  in  1  ALU result == 0 (beq decision)
- dmem_ack  in  1  data-memory access complete
- pc  out  PC_W  current instruction word address
- imem_read_en  out  1  instruction-memory read strobe
- ir_load  out  1  datapath latches instr this cycle
- reg_write_en  out  1  register-file write enable
- reg_dest  out  1  1 = Rd, 0 = Rt destination
- alu_src  out  1  1 = sign-extended immediate, 0 = Rt
- mem_to_reg  out  1  writeback from data memory
- dmem_read  out  1  load request, held until ack
- dmem_write  out  1  store request, held until ack
- alu_op  out  2  00 add, 01 sub, 10 use func
- busy  out  1  FSM not in IDLE/HALT
- halted  out  1  HALT state
- illegal  out  1  sticky unknown-opcode flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, internal opcode/imm registers=0, illegal=0.
  - All strobes and muxes 0; busy=0, halted=0.
- All outputs are registered or Moore-decoded from state plus the latched opcode. No combinational path from instr to any output.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_read_en=1, ir_load=1. Latch instr[31:26] (opcode) and instr[25:0]. Always -> DECODE.
  - DECODE: decode the latched opcode.
    - 111111 (halt) -> HALT.
    - Unknown opcode: illegal<=1, pc<=pc+1, -> FETCH (executes as NOP).
    - Otherwise -> EXEC.
  - EXEC, by opcode:
    - R-type 000000: alu_op=10, alu_src=0 -> WB.
    - addi 001000, lw 100011, sw 101011: alu_op=00, alu_src=1. addi -> WB; lw/sw -> MEM.
    - beq 000100: alu_op=01, alu_src=0. pc<=pc+1+sext(imm16) if alu_zero, else pc+1 -> FETCH.
    - j 000010: pc<={zeros, target26} truncated/zero-extended to PC_W -> FETCH.
  - MEM: dmem_read (lw) or dmem_write (sw) held high, alu_src=1, until dmem_ack=1.
    - On ack, lw -> WB.
    - On ack, sw: pc<=pc+1 -> FETCH.
    - No timeout; waits indefinitely.
  - WB: reg_write_en=1 for exactly one cycle.
    - reg_dest=1 for R-type, 0 otherwise; mem_to_reg=1 for lw only.
    - pc<=pc+1 -> FETCH.
  - HALT: halted=1. start=1 -> FETCH with pc already advanced by 1.
- Cycle counts at zero wait: R/addi 4, lw 5, sw 4, beq/j 3, NOP 2. Each dmem wait cycle adds 1.
- PC arithmetic: modulo 2^PC_W. pc+1 at all-ones wraps to 0; branch offset wraps the same way.
- start is ignored outside IDLE/HALT.
- dmem_ack is ignored outside MEM.
- rst asserted mid-MEM: requests drop immediately (asynchronously); no write strobe is issued.
- illegal clears only on reset.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds 32-bit outputs cycle_cnt (increments every cycle while busy) and instr_cnt (increments on every transition back to FETCH, and on entry to HALT).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset then start, instr=add (0x00221820) -> F,D,E,W sequence. reg_write_en=1 in cycle 4 only, reg_dest=1; pc 0->1.
- lw (0x8C220004) with dmem_ack delayed 2 cycles -> dmem_read high 3 cycles, then WB with mem_to_reg=1. Total 7 cycles; pc=1.
- beq at pc=5, imm=0xFFFE:
  - alu_zero=1 -> pc=4.
  - alu_zero=0 -> pc=6.
  - reg_write_en stays 0 in both cases.
- j target 0x3FFFFFF with PC_W=28 -> pc=0x3FFFFFF. Separately, pc=0xFFFFFFF followed by add -> pc wraps to 0.
- Opcode 0x3F -> halted=1, busy=0. Opcode 0x3E -> illegal=1 sticky, pc+1, next fetch proceeds.
- sw in MEM, rst pulled low before ack -> dmem_write=0 immediately, state IDLE, pc=RESET_PC, no reg write.
